wave_sequencer: RTL
===================

Name: wave_sequencer

Overview:
- Controller ahead of the waveform generator: drives its 3-bit waveform select and 32-bit phase increment.
- Steps through a programmed table of segments. Each segment holds a waveform select, a phase increment and a duration in clk cycles.
- Supports one-shot or looped playback, so chirps, bursts and multi-tone patterns need no host involvement per segment.
- Table and control are written by the host-side register/UART logic. Outputs feed the generator's signalNumber/adder inputs directly.

Parameters:
- DEPTH, 8: number of segment table entries (power of 2, 2..64)
- AW, 3: table address width, log2(DEPTH)
- DUR_W, 24: segment duration counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table entry to write
- cfg_sel  in  3  waveform select for entry
- cfg_adder  in  32  phase increment for entry
- cfg_dur  in  DUR_W  entry duration in cycles
- cfg_delta  in  32  per-cycle increment step (used only with SWEEP_EN)
- seg_count  in  AW+1  number of active segments, 0..DEPTH
- loop_en  in  1  restart at entry 0 after last segment
- start  in  1  start pulse
- stop  in  1  abort pulse
- signalNumber  out  3  to generator waveform select
- adder  out  32  to generator phase increment
- busy  out  1  high while RUN
- seg_idx  out  AW  index of segment currently driven
- done  out  1  one-cycle pulse at sequence end or abort

Behaviour:
- Reset (async, immediate): state=IDLE; signalNumber=0, adder=0, busy=0, seg_idx=0, done=0, duration counter=0. Table contents are not reset (undefined until written).
- Table: DEPTH register entries {sel, adder, dur[, delta]}, read combinationally.
  - Write on posedge clk when cfg_we=1. cfg_addr wraps naturally within AW bits.
  - Writes are permitted in any state. A write to the currently playing entry does not affect the running segment; it takes effect the next time that entry is loaded.
- Effective count N = min(seg_count, DEPTH). Effective duration = max(dur, 1).
- States: IDLE, RUN.
- IDLE:
  - adder=0, which freezes the generator's phase; signalNumber holds its last value; busy=0.
  - start=1 and N>0: next cycle enter RUN with entry 0 loaded, i.e. signalNumber=sel[0], adder=adder[0], seg_idx=0, counter=dur[0]-1, busy=1. Latency is exactly 1 cycle from start to outputs.
  - start=1 and N=0: ignored; no done pulse.
- RUN, each cycle:
  - counter != 0: decrement.
  - counter == 0 and seg_idx < N-1: load entry seg_idx+1 with no gap cycle.
  - counter == 0, last segment, loop_en=1: load entry 0 with no gap cycle.
  - counter == 0, last segment, loop_en=0: go to IDLE, adder=0, done=1 for one cycle.
  - A segment of duration D drives its values for exactly D cycles.
- stop=1 in RUN: next cycle IDLE, adder=0, busy=0, done=1. stop has priority over segment advance and over start.
- start in RUN (without stop): ignored; no restart.
- seg_count or loop_en changed mid-run: sampled at each segment boundary. If N drops so that seg_idx >= N-1, the current segment is treated as the last.
- done is never asserted in the same cycle as busy rising.

Optional Feature:
- Macro SEQ_SWEEP_EN.
- Defined:
  - Each entry also stores cfg_delta.
  - While a segment plays, adder increases by delta every cycle after the load cycle (modulo 2^32, wraps silently); a negative delta gives a down-chirp.
  - The load cycle presents the entry's base adder.
- Undefined:
  - cfg_delta is ignored; there is no delta storage.
  - adder is constant within a segment.

Test Plan:
- Reset mid-RUN: assert rst while busy -> same cycle, busy=0 and adder=0; after release, stays in IDLE until start.
- Entries {0:sel=0,adder=0x01000000,dur=3}, {1:sel=3,adder=0x00400000,dur=2}, N=2, loop_en=0, start pulse -> cycles 1-3 sel=0/adder=0x01000000; cycles 4-5 sel=3/adder=0x00400000; cycle 6 adder=0, done=1, busy=0.
- Same table with loop_en=1 -> continuous 3/2/3/2 pattern with no gap cycles; stop pulse in cycle 7 -> cycle 8 IDLE, done=1.
- dur=0 entry and N=0: start with N=0 -> no busy, no done. Single entry with dur=0 -> plays 1 cycle.
- Simultaneous start+stop in IDLE -> stays IDLE. Write to the playing entry mid-segment -> current values unchanged; new values appear on the next loop pass.
- SEQ_SWEEP_EN: adder=0xFFFFFFF0, delta=0x8, dur=4 -> adder sequence 0xFFFFFFF0, 0xFFFFFFF8, 0x00000000, 0x00000008.

Source files
------------

// File: rtl/wave_sequencer.sv
// wave_sequencer
//   Segment sequencer ahead of the waveform generator. It plays a table of
//   {waveform select, phase increment, duration} entries, once through or
//   looped, and drives the generator's signalNumber / adder inputs.
//
//   Optional feature: define SEQ_SWEEP_EN to give each entry a per-cycle
//   increment step (delta). Within a segment, adder then ramps by delta every
//   cycle after the load cycle. This produces linear chirps.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   cfg_we/addr     table write strobe / entry address
//   cfg_sel/adder   entry waveform select / phase increment
//   cfg_dur         entry duration in cycles (0 is treated as 1)
//   cfg_delta       entry increment step (SEQ_SWEEP_EN only)
//   seg_count       number of active entries (clamped to DEPTH)
//   loop_en         restart at entry 0 after the last entry
//   start, stop     start / abort pulses
//   signalNumber    generator waveform select
//   adder           generator phase increment (0 while idle)
//   busy            high while playing
//   seg_idx         entry currently driven
//   done            one-cycle pulse at sequence end or abort
module wave_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DUR_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [2:0]       cfg_sel,
    input  logic [31:0]      cfg_adder,
    input  logic [DUR_W-1:0] cfg_dur,
    input  logic [31:0]      cfg_delta,
    input  logic [AW:0]      seg_count,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    output logic [2:0]       signalNumber,
    output logic [31:0]      adder,
    output logic             busy,
    output logic [AW-1:0]    seg_idx,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [AW:0] NMAX = (AW+1)'(DEPTH);

    // Segment table, not reset.
    logic [2:0]       tab_sel   [DEPTH];
    logic [31:0]      tab_adder [DEPTH];
    logic [DUR_W-1:0] tab_dur   [DEPTH];
`ifdef SEQ_SWEEP_EN
    logic [31:0]      tab_delta [DEPTH];
    logic [31:0]      delta_q, delta_d;
`else
    logic             unused_delta;
    assign unused_delta = ^cfg_delta;
`endif

    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tab_sel[cfg_addr]   <= cfg_sel;
            tab_adder[cfg_addr] <= cfg_adder;
            tab_dur[cfg_addr]   <= cfg_dur;
`ifdef SEQ_SWEEP_EN
            tab_delta[cfg_addr] <= cfg_delta;
`endif
        end
    end

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [31:0]      adder_q, adder_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [DUR_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [AW:0]      n_eff;
    logic             last_seg;
    logic             ld_en;
    logic [AW-1:0]    ld_idx;

    always_comb begin
        n_eff    = (seg_count > NMAX) ? NMAX : seg_count;
        // seg_count is re-sampled here at every boundary, so shrinking it
        // mid-run simply makes the current entry the last one.
        last_seg = ({1'b0, idx_q} + (AW+1)'(1)) >= n_eff;

        state_d = state_q;
        sel_d   = sel_q;
        adder_d = adder_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        ld_en   = 1'b0;
        ld_idx  = '0;
`ifdef SEQ_SWEEP_EN
        delta_d = delta_q;
`endif

        case (state_q)
            IDLE: begin
                adder_d = '0;  // zero increment freezes generator phase
                if (start && !stop && n_eff != '0) begin
                    ld_en = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    adder_d = '0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DUR_W'(1);
`ifdef SEQ_SWEEP_EN
                    adder_d = adder_q + delta_q;
`endif
                end else if (!last_seg) begin
                    ld_en  = 1'b1;
                    ld_idx = idx_q + AW'(1);
                end else if (loop_en) begin
                    ld_en = 1'b1;
                end else begin
                    state_d = IDLE;
                    adder_d = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entry values are captured into registers here. A table write to the
        // playing entry only shows up at that entry's next load.
        if (ld_en) begin
            state_d = RUN;
            idx_d   = ld_idx;
            sel_d   = tab_sel[ld_idx];
            adder_d = tab_adder[ld_idx];
            cnt_d   = (tab_dur[ld_idx] == '0) ? '0 : tab_dur[ld_idx] - DUR_W'(1);
`ifdef SEQ_SWEEP_EN
            delta_d = tab_delta[ld_idx];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            adder_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef SEQ_SWEEP_EN
            delta_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            adder_q <= adder_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef SEQ_SWEEP_EN
            delta_q <= delta_d;
`endif
        end
    end

    assign signalNumber = sel_q;
    assign adder        = adder_q;
    assign busy         = (state_q == RUN);
    assign seg_idx      = idx_q;
    assign done         = done_q;

endmodule
